// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment scanner with anti-ghost blanking, hex/status glyphs and per-digit blink
module seg7_scan_driver #(
   parameter int NUM_DIGITS           = 4,
   parameter int COMMON_ANODE_CATHODE = 0,
   parameter int DIG_ACTIVE_HIGH      = 0,
   parameter int REFRESH_DIV          = 50000,
   parameter int DEAD_CYCLES          = 16,
   parameter int BLINK_SCANS          = 64
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [4*NUM_DIGITS-1:0] i_data,
   input  logic                    i_load,
   input  logic                    i_mode,
   input  logic [NUM_DIGITS-1:0]   i_blank_mask,
   input  logic [NUM_DIGITS-1:0]   i_blink_en,
   output logic [6:0]              o_seg,
   output logic [NUM_DIGITS-1:0]   o_dig,
   output logic                    o_scan_done
);
   localparam int CMAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
   localparam int CW   = $clog2(CMAX);
   localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int BW   = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
   localparam logic [6:0]            SEG_OFF    = {7{COMMON_ANODE_CATHODE == 0}};
   localparam logic [NUM_DIGITS-1:0] DIG_OFF    = {NUM_DIGITS{DIG_ACTIVE_HIGH == 0}};
   localparam logic [CW-1:0]         DEAD_LAST  = CW'(DEAD_CYCLES - 1);
   localparam logic [CW-1:0]         DRIVE_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
   localparam logic [BW-1:0]         BLINK_LAST = BW'(BLINK_SCANS - 1);

   typedef enum logic {BLANK, DRIVE} state_t;

   state_t                  r_state, w_state_nxt;
   logic [CW-1:0]           r_cnt, w_cnt_nxt;
   logic [IW-1:0]           r_idx, w_idx_nxt;
   logic [BW-1:0]           r_scans;
   logic                    r_run, r_phase, r_scan_done;
   logic [4*NUM_DIGITS-1:0] r_shadow;
   logic [6:0]              r_seg;
   logic [NUM_DIGITS-1:0]   r_dig;
   logic                    w_start, w_stop, w_wrap, w_dark;
   logic [3:0]              w_nib;
   logic [6:0]              w_glyph, w_seg_on;
   logic [NUM_DIGITS-1:0]   w_dig_on;

   function automatic logic [6:0] f_hex(input logic [3:0] n);
      case (n)
         4'h0: f_hex = 7'h7E;
         4'h1: f_hex = 7'h30;
         4'h2: f_hex = 7'h6D;
         4'h3: f_hex = 7'h79;
         4'h4: f_hex = 7'h33;
         4'h5: f_hex = 7'h5B;
         4'h6: f_hex = 7'h5F;
         4'h7: f_hex = 7'h70;
         4'h8: f_hex = 7'h7F;
         4'h9: f_hex = 7'h7B;
         4'hA: f_hex = 7'h77;
         4'hB: f_hex = 7'h1F;
         4'hC: f_hex = 7'h4E;
         4'hD: f_hex = 7'h3D;
         4'hE: f_hex = 7'h4F;
         default: f_hex = 7'h47;
      endcase
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_run ? r_cnt + CW'(1) : r_cnt;
      w_idx_nxt   = r_idx;
      w_start     = 1'b0;
      w_stop      = 1'b0;
      if (r_run && r_state == BLANK && r_cnt == DEAD_LAST) begin
         w_state_nxt = DRIVE;
         w_cnt_nxt   = '0;
         w_start     = 1'b1;
      end else if (r_state == DRIVE && r_cnt == DRIVE_LAST) begin
         w_state_nxt = BLANK;
         w_cnt_nxt   = '0;
         w_stop      = 1'b1;
         w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      end
   end

   assign w_wrap   = w_stop && (r_idx == IDX_LAST);
   assign w_nib    = r_shadow[4*r_idx +: 4];
   assign w_dark   = i_blank_mask[r_idx] | (i_blink_en[r_idx] & r_phase);
   assign w_glyph  = !i_mode ? f_hex(w_nib) :
                     (w_nib == 4'h0) ? 7'h00 :
                     (w_nib inside {4'h4, 4'h5, 4'h6, 4'hA, 4'hE, 4'hF}) ? f_hex(w_nib) : 7'h67;
   assign w_seg_on = w_dark ? 7'h00 : w_glyph;
   assign w_dig_on = w_dark ? '0 : NUM_DIGITS'(1) << r_idx;

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_state <= BLANK;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_run   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_run   <= 1'b1;
      end

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n)
         r_shadow <= '0;
      else if (i_load)
         r_shadow <= i_data;

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_seg <= SEG_OFF;
         r_dig <= DIG_OFF;
      end else if (w_start) begin
         r_seg <= w_seg_on ^ SEG_OFF;
         r_dig <= w_dig_on ^ DIG_OFF;
      end else if (w_stop) begin
         r_seg <= SEG_OFF;
         r_dig <= DIG_OFF;
      end

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_scans     <= '0;
         r_phase     <= 1'b0;
         r_scan_done <= 1'b0;
      end else begin
         r_scan_done <= w_wrap;
         if (w_wrap) begin
            r_scans <= (r_scans == BLINK_LAST) ? '0 : r_scans + BW'(1);
            r_phase <= (r_scans == BLINK_LAST) ? ~r_phase : r_phase;
         end
      end

   assign o_seg       = r_seg;
   assign o_dig       = r_dig;
   assign o_scan_done = r_scan_done;
endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: digit count, legal 1..8.
REQ-002 SHALL have parameter COMMON_ANODE_CATHODE, default 0: 0 = segments active-low, 1 = segments active-high.
REQ-003 SHALL have parameter DIG_ACTIVE_HIGH, default 0: digit-enable polarity, 1 = active-high, 0 = active-low.
REQ-004 SHALL have parameter REFRESH_DIV, default 50000: cycles each digit is driven, legal >=2.
REQ-005 SHALL have parameter DEAD_CYCLES, default 16: anti-ghost cycles between digits, legal >=1.
REQ-006 SHALL have parameter BLINK_SCANS, default 64: completed scans per blink half-period, legal >=1.
REQ-007 SHALL have ports i_clk, input, 1, the single clock, rising edge; i_rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports i_data, input, 4*NUM_DIGITS, nibble k = digit k; i_load, input, 1, capture strobe.
REQ-009 SHALL have ports i_mode, input, 1, 0 = hex glyphs, 1 = status glyphs; i_blank_mask, input, NUM_DIGITS, 1 = digit always dark; i_blink_en, input, NUM_DIGITS, 1 = digit blinks.
REQ-010 SHALL have ports o_seg, output, 7, {a,b,c,d,e,f,g}; o_dig, output, NUM_DIGITS, digit enables; o_scan_done, output, 1, end-of-scan pulse.

Function
REQ-011 SHALL hold a shadow register loaded from i_data on every cycle with i_load=1; it holds otherwise.
REQ-012 SHALL run a two-state FSM: BLANK, lasting DEAD_CYCLES cycles, then DRIVE, lasting REFRESH_DIV cycles, then back to BLANK.
REQ-013 SHALL drive all o_dig bits inactive and o_seg all-off in BLANK.
REQ-014 SHALL, on the BLANK->DRIVE transition, register the glyph of shadow nibble idx; o_seg and o_dig stay constant for the whole DRIVE period, and i_load mid-DRIVE affects only later digits.
REQ-015 SHALL, in DRIVE, activate only o_dig[idx], unless i_blank_mask[idx]=1, or i_blink_en[idx]=1 with blink phase=1; in those cases all o_dig stay inactive and o_seg is all-off.
REQ-016 SHALL advance idx at the end of DRIVE, wrapping from NUM_DIGITS-1 to 0.
REQ-017 SHALL pulse o_scan_done high for exactly one cycle, registered, in the cycle after the wrap transition.
REQ-018 SHALL count completed scans and toggle the blink phase when the count reaches BLINK_SCANS, then clear the count; the count and the phase change in the same cycle as the o_scan_done assertion.
REQ-019 SHALL, for i_mode=0, use these hex glyphs ({a..g} hex, active-high): 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47.
REQ-020 SHALL, for i_mode=1, use these status glyphs: 0=00 (off), 4=33 (Y), 5=5B (S), 6=5F (G), A=77 (A), E=4F (E), F=47 (F), all other codes 67 (P).
REQ-021 SHALL sample i_mode only at BLANK->DRIVE.
REQ-022 SHALL apply polarity last: o_seg is inverted when COMMON_ANODE_CATHODE=0, and o_dig is inverted when DIG_ACTIVE_HIGH=0.
REQ-023 SHALL size counters as clog2 of their maxima; at NUM_DIGITS=1, idx is constant 0 and o_scan_done pulses after every DRIVE.
REQ-024 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-025 SHALL, while i_rst_n=0, immediately force: state BLANK, idx 0, cycle counter 0, scan counter 0, blink phase 0, shadow register 0.
REQ-026 SHALL, while i_rst_n=0, immediately force o_seg all-off (7'h7F at COMMON_ANODE_CATHODE=0), all o_dig bits inactive, and o_scan_done 0.
REQ-027 SHALL, after release, make the first DRIVE of digit 0 begin DEAD_CYCLES cycles after the first rising edge with i_rst_n=1; reset asserted mid-DRIVE darkens the display at once.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1, BLINK_SCANS=2, COMMON_ANODE_CATHODE=0, DIG_ACTIVE_HIGH=0)
REQ-028 SHALL cover: load 16'h3A50, i_mode=0, no masks -> each digit is active for 4 cycles and dark for 1, in order 0..3.
    - digit0 o_seg=7'h01, o_dig=4'b1110; digit1 o_seg=7'h24, o_dig=4'b1101.
    - o_scan_done pulses once every 20 cycles.
REQ-029 SHALL cover: i_mode=1, load 16'h6F40 -> digit0 o_seg=7'h7F (off), digit1 7'h4C (Y), digit2 7'h38 (F), digit3 7'h20 (G); i_data=4'h2 on digit0 -> 7'h18 (P).
REQ-030 SHALL cover: i_blink_en=4'b0010 -> digit1 is dark for scans 3-4, lit for scans 5-6, dark for scans 7-8; other digits are unaffected.
REQ-031 SHALL cover: i_blank_mask=4'b1000 -> o_dig[3] is never active; the digit3 slot still consumes 5 cycles; o_scan_done timing is unchanged.
REQ-032 SHALL cover: i_load with new data in cycle 2 of digit1 DRIVE -> digit1 o_seg is unchanged for that slot and the new value appears at the next visit.
REQ-033 SHALL cover: i_rst_n low for 1 cycle mid-DRIVE of digit2 -> outputs go inactive asynchronously and the shadow is cleared; after release, digit0 shows 7'h01 after 1 dead cycle.
